// File: rtl/data_mem_responder_pkg.sv
// Shared CPU definitions for the data-memory responder: access types, MMIO map, error bits.
// Pure constants and a size decoder; no logic state.
package data_mem_responder_pkg;

  localparam logic [2:0] RW_BYTE  = 3'b000;
  localparam logic [2:0] RW_HALF  = 3'b001;
  localparam logic [2:0] RW_WORD  = 3'b010;
  localparam logic [2:0] RW_BYTEU = 3'b100;
  localparam logic [2:0] RW_HALFU = 3'b101;

  // Register selects within the 4 KB window, taken from ram_addr[3:2]
  localparam logic [1:0] MMIO_CYCLE_LO = 2'd0;
  localparam logic [1:0] MMIO_CYCLE_HI = 2'd1;
  localparam logic [1:0] MMIO_TOHOST   = 2'd2;
  localparam logic [1:0] MMIO_STATUS   = 2'd3;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_OOB      = 1;
  localparam int ERR_TYPE     = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } acc_size_e;

  function automatic acc_size_e decode_size(input logic [2:0] rw_type);
    case (rw_type)
      RW_BYTE, RW_BYTEU: return SZ_BYTE;
      RW_HALF, RW_HALFU: return SZ_HALF;
      RW_WORD:           return SZ_WORD;
      default:           return SZ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between core and data memory.
// Loads answer combinationally in the request cycle; there is no backpressure.
interface data_mem_responder_if;
  logic        R_en;
  logic        W_en;
  logic [2:0]  RW_type;
  logic [31:0] ram_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  modport master (
    output R_en, W_en, RW_type, ram_addr, store_data,
    input  load_data
  );

  modport slave (
    input  R_en, W_en, RW_type, ram_addr, store_data,
    output load_data
  );
endinterface

// File: rtl/data_mem_responder_load_extend.sv
// Load lane select plus sign/zero extension; purely combinational, zero latency.
// No backpressure: output follows inputs every cycle.
module data_mem_responder_load_extend
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  rw_type,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{lane, 3'b000} +: 8];
    h    = lane[1] ? word[31:16] : word[15:0];
    data = '0;
    case (rw_type)
      RW_BYTE:  data = {{24{b[7]}}, b};
      RW_BYTEU: data = {24'b0, b};
      RW_HALF:  data = {{16{h[15]}}, h};
      RW_HALFU: data = {16'b0, h};
      RW_WORD:  data = word;
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM + MMIO register window: zero-latency loads, stores/side effects commit on clk.
// No backpressure: every request is accepted; bad accesses are dropped and flagged in err.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus,
  output logic [31:0]           tohost,
  output logic                  test_done,
  output logic [2:0]            err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [63:0]   cycle_cnt;
  logic [31:0]   cycle_hi_snap;

  acc_size_e     size;
  logic          active, is_mmio, is_ram, mmio_reg;
  logic          bad_type, misalign, oob, ok;
  logic [2:0]    new_err, clr_mask;
  logic [AW-1:0] word_idx;
  logic [1:0]    reg_sel;
  logic [3:0]    be;
  logic [31:0]   wdata, rd_word, ext_data;
  logic          ram_we, tohost_we, status_we, snap_we;

  always_comb begin
    active   = bus.R_en | bus.W_en;
    size     = decode_size(bus.RW_type);
    reg_sel  = bus.ram_addr[3:2];
    word_idx = bus.ram_addr[AW+1:2];
    is_mmio  = bus.ram_addr[31:12] == MMIO_BASE[31:12];
    is_ram   = !is_mmio && ((bus.ram_addr >> (AW + 2)) == 32'd0);
    mmio_reg = is_mmio && (bus.ram_addr[11:4] == 8'd0);

    // MMIO registers are word-only, so a narrow MMIO access is a type fault
    bad_type = (size == SZ_BAD) || (is_mmio && size != SZ_WORD);
    misalign = ((size == SZ_HALF) && bus.ram_addr[0]) ||
               ((size == SZ_WORD) && (bus.ram_addr[1:0] != 2'b00));
    oob      = !(is_ram || mmio_reg);

    new_err = '0;
    if (active) begin
      new_err[ERR_TYPE]     = bad_type;
      new_err[ERR_MISALIGN] = !bad_type && misalign;
      new_err[ERR_OOB]      = !bad_type && oob;
    end
    ok = active && (new_err == 3'b000);

    ram_we    = ok && bus.W_en && is_ram;
    tohost_we = ok && bus.W_en && is_mmio && (reg_sel == MMIO_TOHOST);
    status_we = ok && bus.W_en && is_mmio && (reg_sel == MMIO_STATUS);
    snap_we   = ok && !bus.W_en && is_mmio && (reg_sel == MMIO_CYCLE_LO);
    clr_mask  = status_we ? bus.store_data[2:0] : 3'b000;

    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << bus.ram_addr[1:0];
        wdata = {4{bus.store_data[7:0]}};
      end
      SZ_HALF: begin
        be    = bus.ram_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.store_data;
      end
    endcase
  end

  always_comb begin
    rd_word = mem[word_idx];
    if (is_mmio) begin
      case (reg_sel)
        MMIO_CYCLE_LO: rd_word = cycle_cnt[31:0];
        MMIO_CYCLE_HI: rd_word = cycle_hi_snap;
        MMIO_TOHOST:   rd_word = tohost;
        default:       rd_word = {29'b0, err};
      endcase
    end
  end

  data_mem_responder_load_extend u_load_extend (
    .word    (rd_word),
    .lane    (bus.ram_addr[1:0]),
    .rw_type (bus.RW_type),
    .data    (ext_data)
  );

  assign bus.load_data = (ok && !bus.W_en) ? ext_data : '0;

  // RAM keeps its contents across reset; a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt     <= '0;
      cycle_hi_snap <= '0;
      tohost        <= '0;
      test_done     <= 1'b0;
      err           <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (snap_we) cycle_hi_snap <= cycle_cnt[63:32];
      if (tohost_we) begin
        tohost    <= bus.store_data;
        test_done <= 1'b1;
      end
      // New faults are OR-ed after the clear so a same-edge set wins
      err <= (err & ~clr_mask) | new_err;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized + directed bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int          DW = 1024;
  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tohost;
  logic        test_done;
  logic [2:0]  err;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DW), .MMIO_BASE(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .tohost    (tohost),
    .test_done (test_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: memory as little-endian bytes, registers as plain values
  logic [7:0]  mem_m [0:DW*4-1];
  logic [63:0] cnt_m    = '0;
  logic [31:0] snap_m   = '0;
  logic [31:0] tohost_m = '0;
  logic        done_m   = 1'b0;
  logic [2:0]  err_m    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] t);
    if (t == 3'd0 || t == 3'd4) return 1;
    if (t == 3'd1 || t == 3'd5) return 2;
    if (t == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic in_mmio(input logic [31:0] a);
    return (a >> 12) == (MB >> 12);
  endfunction

  function automatic logic in_ram(input logic [31:0] a);
    return !in_mmio(a) && (a < DW * 4);
  endfunction

  function automatic logic [31:0] model_load(input logic r, input logic w, input logic [2:0] t,
                                             input logic [31:0] a, output logic [2:0] e);
    int          nb;
    logic        oor;
    logic [31:0] v;
    e   = 3'b000;
    nb  = nbytes(t);
    oor = !in_ram(a) && !(in_mmio(a) && ((a & 32'hFFF) < 32'd16));
    if (!(r || w)) return 32'd0;
    if (nb == 0 || (in_mmio(a) && nb != 4)) e = 3'b100;
    else begin
      e[0] = (a % nb) != 0;
      e[1] = oor;
    end
    if (w || e != 3'b000) return 32'd0;
    v = 32'd0;
    if (in_ram(a)) begin
      for (int k = 0; k < nb; k++) v = v | (32'(mem_m[a + k]) << (8 * k));
      if (t < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    end else begin
      case (a & 32'hFFF)
        32'd0:   v = cnt_m[31:0];
        32'd4:   v = snap_m;
        32'd8:   v = tohost_m;
        default: v = {29'b0, err_m};
      endcase
    end
    return v;
  endfunction

  task automatic model_step();
    logic [2:0]  e, clr;
    logic [31:0] a, d, unused_ld;
    a   = bus.ram_addr;
    d   = bus.store_data;
    unused_ld = model_load(bus.R_en, bus.W_en, bus.RW_type, a, e);
    clr = 3'b000;
    if (e == 3'b000 && bus.W_en) begin
      if (in_ram(a)) begin
        for (int k = 0; k < nbytes(bus.RW_type); k++) mem_m[a + k] = d[8*k +: 8];
      end else if ((a & 32'hFFF) == 32'd8) begin
        tohost_m = d;
        done_m   = 1'b1;
      end else if ((a & 32'hFFF) == 32'd12) begin
        clr = d[2:0];
      end
    end
    if (e == 3'b000 && bus.R_en && !bus.W_en && in_mmio(a) && (a & 32'hFFF) == 32'd0)
      snap_m = cnt_m[63:32];
    err_m = (err_m & ~clr) | e;
    cnt_m = cnt_m + 64'd1;
  endtask

  task automatic model_reset();
    cnt_m    = '0;
    snap_m   = '0;
    tohost_m = '0;
    done_m   = 1'b0;
    err_m    = '0;
  endtask

  always @(posedge clk) if (rst_n) model_step();

  // Single compare process: every cycle, all outputs against the model
  always @(negedge clk) begin
    logic [2:0]  e;
    logic [31:0] ld;
    ld = model_load(bus.R_en, bus.W_en, bus.RW_type, bus.ram_addr, e);
    check("load_data", bus.load_data, ld);
    check("tohost", tohost, tohost_m);
    check("test_done", {31'b0, test_done}, {31'b0, done_m});
    check("err", {29'b0, err}, {29'b0, err_m});
  end

  task automatic drive(input logic r, input logic w, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.R_en       = r;
    bus.W_en       = w;
    bus.RW_type    = t;
    bus.ram_addr   = a;
    bus.store_data = d;
  endtask

  task automatic op(input logic r, input logic w, input logic [2:0] t,
                    input logic [31:0] a, input logic [31:0] d);
    drive(r, w, t, a, d);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, RW_WORD, 32'd0, 32'd0);
  endtask

  // Hand-computed expectation checked against both the DUT and the model
  task automatic lit(input string name, input logic [31:0] exp);
    logic [2:0]  e;
    logic [31:0] m;
    m = model_load(bus.R_en, bus.W_en, bus.RW_type, bus.ram_addr, e);
    check(name, bus.load_data, exp);
    check({name, "_model"}, m, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] lo;
    int          sel;

    bus.R_en = 1'b0; bus.W_en = 1'b0; bus.RW_type = RW_WORD;
    bus.ram_addr = '0; bus.store_data = '0;
    #2;
    check("rst_load", bus.load_data, 32'd0);
    check("rst_tohost", tohost, 32'd0);
    check("rst_done", {31'b0, test_done}, 32'd0);
    check("rst_err", {29'b0, err}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Cycle counter after ~100 idle cycles, high snapshot still zero
    repeat (100) @(posedge clk);
    op(1'b1, 1'b0, RW_WORD, MB + 32'h0, 32'd0);
    lo = bus.load_data;
    n_vec++;
    if (lo < 32'd100 || lo > 32'd110) begin
      n_err++;
      $display("FAIL cycle_lo_100: got %0d expected 100..110", lo);
    end
    op(1'b1, 1'b0, RW_WORD, MB + 32'h4, 32'd0);
    lit("cycle_hi_0", 32'd0);

    for (int i = 0; i < DW; i++) op(1'b0, 1'b1, RW_WORD, 32'(i * 4), $urandom);

    op(1'b0, 1'b1, RW_WORD, 32'h10, 32'h8765_4321);
    op(1'b1, 1'b0, RW_BYTE, 32'h10, 32'd0);   lit("lb_10", 32'h0000_0021);
    op(1'b1, 1'b0, RW_BYTE, 32'h13, 32'd0);   lit("lb_13", 32'hFFFF_FF87);
    op(1'b1, 1'b0, RW_HALFU, 32'h12, 32'd0);  lit("lhu_12", 32'h0000_8765);
    op(1'b1, 1'b0, RW_HALF, 32'h12, 32'd0);   lit("lh_12", 32'hFFFF_8765);

    op(1'b0, 1'b1, RW_WORD, 32'h20, 32'd0);
    op(1'b0, 1'b1, RW_BYTE, 32'h21, 32'h0000_00AB);
    op(1'b1, 1'b0, RW_WORD, 32'h20, 32'd0);   lit("lw_sb", 32'h0000_AB00);
    op(1'b0, 1'b1, RW_HALF, 32'h22, 32'h0000_BEEF);
    op(1'b1, 1'b0, RW_WORD, 32'h20, 32'd0);   lit("lw_sh", 32'hBEEF_AB00);

    op(1'b1, 1'b0, RW_WORD, 32'h02, 32'd0);   lit("lw_misalign", 32'd0);
    idle(); check("err_misalign", {29'b0, err}, 32'd1);
    op(1'b0, 1'b1, RW_WORD, MB + 32'hC, 32'd1);
    idle(); check("err_cleared", {29'b0, err}, 32'd0);
    op(1'b1, 1'b0, RW_WORD, 32'h02, 32'd0);
    op(1'b0, 1'b1, RW_WORD, MB + 32'hE, 32'd1);
    idle(); check("err_set_wins", {29'b0, err}, 32'd1);

    // Counter wrap at 2^64-1
    @(posedge clk); #1;
    force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    cnt_m = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.R_en = 1'b1; bus.W_en = 1'b0; bus.RW_type = RW_WORD; bus.ram_addr = MB;
    #1 release dut.cycle_cnt;
    @(negedge clk); #1;
    lit("cycle_lo_max", 32'hFFFF_FFFF);
    op(1'b1, 1'b0, RW_WORD, MB + 32'h0, 32'd0); lit("cycle_lo_wrap", 32'd0);
    op(1'b1, 1'b0, RW_WORD, MB + 32'h4, 32'd0); lit("cycle_hi_wrap", 32'd0);

    op(1'b0, 1'b1, RW_WORD, MB + 32'h8, 32'd1);
    idle();
    check("tohost_1", tohost, 32'd1);
    check("done_1", {31'b0, test_done}, 32'd1);
    op(1'b0, 1'b1, RW_WORD, MB + 32'h8, 32'd2);
    idle();
    check("tohost_2", tohost, 32'd2);
    check("done_sticky", {31'b0, test_done}, 32'd1);

    // Reset mid-run with a store in flight
    drive(1'b0, 1'b1, RW_WORD, 32'h10, 32'hDEAD_BEEF);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_tohost", tohost, 32'd0);
    check("midrst_done", {31'b0, test_done}, 32'd0);
    check("midrst_err", {29'b0, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.W_en = 1'b0;
    op(1'b1, 1'b0, RW_WORD, 32'h10, 32'd0);   lit("ram_kept", 32'h8765_4321);

    for (int i = 0; i < 2000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = $urandom_range(0, DW * 4 - 1);
      else if (sel < 9) a = MB + $urandom_range(0, 31);
      else              a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)), a, $urandom);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two).
REQ-002 Parameter MMIO_BASE, default 32'h8000_0000, base of 4 KB register window (4 KB aligned).
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port R_en  input  1  load request from the core's MEM stage.
REQ-006 Port W_en  input  1  store request from the core's MEM stage.
REQ-007 Port RW_type  input  3  access type, funct3 encoding: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-008 Port ram_addr  input  32  byte address.
REQ-009 Port store_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 Port load_data  output  32  load result, extended to 32 bits.
REQ-011 Port tohost  output  32  last value written to TOHOST.
REQ-012 Port test_done  output  1  sticky flag, set by first TOHOST write.
REQ-013 Port err  output  3  sticky status {type_err, oob_err, misalign_err}.

Function
REQ-014 Load is zero-latency: load_data is combinational from R_en, RW_type, ram_addr and current storage, in the same cycle.
REQ-015 Stores commit on the rising clk edge when W_en=1; no stall or ready signal exists.
REQ-016 load_data = 0 whenever R_en=0, W_en=1, or the access is in error.
REQ-017 R_en=1 with W_en=1 in the same cycle: treated as a store only.
REQ-018 RAM hit: ram_addr[31:12] != MMIO_BASE[31:12] and ram_addr < DEPTH_WORDS*4; word index = ram_addr[log2(DEPTH_WORDS)+1:2].
REQ-019 Byte access: lane ram_addr[1:0]; half access: lane ram_addr[1]; stores write only the addressed byte lanes.
REQ-020 Signed loads sign-extend from bit 7/15; unsigned loads zero-extend.
REQ-021 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): no write, load 0, set misalign_err on next edge.
REQ-022 Out-of-range access (neither RAM nor MMIO): no write, load 0, set oob_err.
REQ-023 RW_type 011/110/111 with R_en or W_en: no access, load 0, set type_err.
REQ-024 MMIO window offsets (word-only; other widths raise type_err): 0x0 CYCLE_LO (RO), 0x4 CYCLE_HI (RO), 0x8 TOHOST (RW), 0xC STATUS (read = {29'b0, err}; write-1-to-clear per bit); other offsets raise oob_err.
REQ-025 64-bit cycle counter increments every clk edge, wraps from 2^64-1 to 0.
REQ-026 Reading CYCLE_LO returns the live low word and latches the live high word into a snapshot on that edge; CYCLE_HI returns the snapshot.
REQ-027 TOHOST write updates tohost every time; test_done sets on the first write and stays set.
REQ-028 STATUS clear and a new error on the same edge: the set wins for that bit.
REQ-029 Writes to read-only MMIO registers are ignored without error.

Reset
REQ-030 On rst_n low, immediately: cycle counter 0, CYCLE_HI snapshot 0, tohost 0, test_done 0, err 0.
REQ-031 RAM contents are not cleared by reset; stores in flight at reset assertion are discarded.
REQ-032 With R_en=W_en=0 during reset, load_data = 0.

Structure
REQ-033 RW_type encodings, MMIO offsets and err bit positions are defined as constants in the shared CPU definitions package.
REQ-034 One sub-module, load_extend, performs lane selection and sign/zero extension (combinational).

Verification
REQ-035 sw 0x8765_4321 @0x10; then lb @0x10 -> 0x0000_0021, lb @0x13 -> 0xFFFF_FF87, lhu @0x12 -> 0x0000_8765, lh @0x12 -> 0xFFFF_8765.
REQ-036 sw 0 @0x20; sb 0xAB @0x21; lw @0x20 -> 0x0000_AB00; sh 0xBEEF @0x22; lw @0x20 -> 0xBEEF_AB00.
REQ-037 lw @0x02 -> load_data 0, err=3'b001 next cycle; write STATUS 0x1 -> err=0; same-edge clear and new misalign -> err stays 3'b001.
REQ-038 Run 100 cycles after reset; lw CYCLE_LO then CYCLE_HI -> lo within 100..110 of counter, hi 0; force counter to 0xFFFF_FFFF_FFFF_FFFF -> wraps to 0 next edge.
REQ-039 sw 0x1 to MMIO_BASE+0x8 -> tohost=1, test_done=1; sw 0x2 -> tohost=2, test_done remains 1; rst_n low mid-run -> tohost=0, test_done=0, err=0 immediately, RAM word @0x10 unchanged.
